// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame types and helper functions
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Data-size code to bit count: 6, 7, 8 map to themselves, everything else is 9.
    function automatic logic [3:0] decode_data_size(input logic [3:0] code);
        case (code)
            4'd6, 4'd7, 4'd8: return code;
            default:          return 4'd9;
        endcase
    endfunction

    // Parity over the low n bits; even=1 gives ^data, even=0 gives ~^data.
    function automatic logic calc_parity(input logic [8:0] data,
                                         input logic [3:0] n,
                                         input logic       even);
        logic [8:0] masked;
        masked = '0;
        for (int i = 0; i < 9; i++) begin
            if (i < int'(n)) masked[i] = data[i];
        end
        return even ? ^masked : ~^masked;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, resets to 1 (idle line level)
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // Two back-to-back flops to resolve metastability on the async serial line.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/rx_module.sv
// rtl/rx_module.sv - oversampling UART receiver with parity and framing status
module rx_module
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en,
    input  logic [3:0] data_size_i,
    input  logic       parity_size_i,
    input  logic       parity_type_i,
    input  logic [1:0] stop_size_i,
    input  logic       rx,
    output logic [8:0] data_o,
    output logic       rx_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       rx_busy_o
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [3:0]       n_q, n_d;
    logic             par_en_q, par_en_d;
    logic             par_type_q, par_type_d;
    logic [8:0]       shift_q, shift_d;
    logic             par_mis_q, par_mis_d;
    logic [8:0]       data_q, data_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             valid_q, valid_d;
    logic             rx_prev_q;
    logic             rx_s;
    logic             fall;
    logic             unused_stop_size;

    // The stop-bit count only matters to the transmitter; the receiver re-arms after the first.
    assign unused_stop_size = ^stop_size_i;

    sync_2ff u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (rx),
        .q_o    (rx_s)
    );

    // A held-low line (break) never looks like a new start: an explicit 1->0 edge is required.
    assign fall = rx_prev_q & ~rx_s;

    // Next-state and datapath: sample mid-start at half period, every later bit at full period.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        n_d        = n_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        shift_d    = shift_q;
        par_mis_d  = par_mis_q;
        data_d     = data_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        valid_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (en && fall) begin
                    state_d    = START;
                    n_d        = decode_data_size(data_size_i);
                    par_en_d   = parity_size_i;
                    par_type_d = parity_type_i;
                    bit_cnt_d  = 4'd0;
                    cnt_d      = '0;
                    shift_d    = '0;
                    par_mis_d  = 1'b0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d             = '0;
                    shift_d[bit_cnt_q] = rx_s;
                    bit_cnt_d         = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == n_q - 4'd1) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    par_mis_d = rx_s ^ calc_parity(shift_q, n_q, par_type_q);
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    valid_d = 1'b1;
                    data_d  = shift_q;
                    perr_d  = par_en_q & par_mis_q;
                    ferr_d  = ~rx_s;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Disable aborts any frame in flight without touching the presented word.
        if (state_q != IDLE && !en) begin
            state_d = IDLE;
            valid_d = 1'b0;
            data_d  = data_q;
            perr_d  = perr_q;
            ferr_d  = ferr_q;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= 4'd0;
            n_q        <= 4'd9;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            shift_q    <= '0;
            par_mis_q  <= 1'b0;
            data_q     <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            valid_q    <= 1'b0;
            rx_prev_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            n_q        <= n_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            shift_q    <= shift_d;
            par_mis_q  <= par_mis_d;
            data_q     <= data_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            valid_q    <= valid_d;
            rx_prev_q  <= rx_s;
        end
    end

    assign data_o       = data_q;
    assign rx_valid_o   = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign rx_busy_o    = (state_q != IDLE);

endmodule

// File: doc/rx_module.md
Name: rx_module

Overview:
- UART-style serial receiver. It is the counterpart of the system's transmitter and shares its frame format: 1 start bit (0), 6–9 data bits LSB first, optional parity bit, then stop bits (1).
- It oversamples the serial line, validates the start bit and samples each bit at mid-period.
- It presents the received word with parity and framing status to the peripheral register/bus layer.

Parameters:
- CLKS_PER_BIT, 16: clk_i cycles per serial bit. Must be ≥4 and even.
- CNT_W, $clog2(CLKS_PER_BIT): width of the bit-period counter.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous, active-low reset
- en  in  1  receiver enable
- data_size_i  in  4  data bits per frame. 6, 7, 8 give that count; any other value gives 9.
- parity_size_i  in  1  0 = no parity bit, 1 = parity bit present
- parity_type_i  in  1  1 = even (parity bit = ^data), 0 = odd (parity bit = ~^data)
- stop_size_i  in  2  configured stop bits. Only the first stop bit is checked.
- rx  in  1  asynchronous serial line, idle high
- data_o  out  9  received word, right-aligned, unused upper bits 0
- rx_valid_o  out  1  one-cycle pulse: data_o and the error flags are updated
- parity_err_o  out  1  parity mismatch on the last frame
- frame_err_o  out  1  first stop bit sampled 0 on the last frame
- rx_busy_o  out  1  high while not in IDLE

Behaviour:
- Reset (rst_ni low at a clk_i edge):
  - state = IDLE.
  - data_o = 0, rx_valid_o = 0, parity_err_o = 0, frame_err_o = 0, rx_busy_o = 0.
  - Synchronizer flops = 1.
  - Reset mid-frame discards the frame with no valid pulse.
- Input synchronization: rx passes through a 2-flop synchronizer (rx_s). Edge detection uses rx_s and its 1-cycle delay.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - A falling edge on rx_s with en = 1 moves to START.
  - On that edge, capture the configuration (decoded data bit count N, parity enable, parity type). Config changes mid-frame have no effect.
  - Clear the bit counter and load the period counter with 0.
- START:
  - At period count CLKS_PER_BIT/2-1, sample rx_s.
  - Sample 1: false start, go to IDLE with no pulse.
  - Sample 0: restart the period counter and go to DATA.
- Bit sampling: after START, every state samples at period count CLKS_PER_BIT-1, i.e. the mid-point of each subsequent bit.
- DATA:
  - Each sample shifts into bit position [bit_cnt]. LSB is received first.
  - After N samples, go to PARITY if parity is enabled, else STOP.
- PARITY: the sampled bit is compared with the parity computed over the N received bits, using the captured parity_type.
- STOP:
  - Sample the first stop bit.
  - Next cycle, return to IDLE and pulse rx_valid_o for one cycle.
  - With that pulse: data_o = received word (bits ≥N are 0), parity_err_o = mismatch (0 if parity is disabled), frame_err_o = ~stop_sample.
  - Additional configured stop bits are not checked. The receiver re-arms at the mid-point of the first stop bit, which allows back-to-back frames.
- Frame error with break: if frame_err_o is set and rx_s is still 0 when IDLE is re-entered, no new start is detected until rx_s has returned to 1 (this needs an explicit falling edge).
- Hold rules: data_o and the error flags hold until the next rx_valid_o. There is no buffering; the consumer must take data_o before the next frame completes.
- en deasserted in any non-IDLE state: abort to IDLE next cycle, no pulse, outputs unchanged.
- Latency:
  - Falling edge at pin to start-bit sample: 2 (sync) + CLKS_PER_BIT/2 cycles.
  - rx_valid_o is asserted 1 cycle after the stop-bit sample.
- Widths: the period counter is CNT_W bits and wraps to 0 on reaching CLKS_PER_BIT-1. The bit counter is 4 bits.

Decomposition:
- Shared package uart_pkg holds:
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - Data-size decode function: 4-bit code → 6..9.
  - Parity function (data, N, type) → bit, used identically by the transmitter.
- One natural sub-module: sync_2ff, the 2-flop synchronizer with reset value 1.

Test Plan (CLKS_PER_BIT = 4):
- 8N1, byte 0xA5, correct timing → one rx_valid_o; data_o = 0x0A5, parity_err_o = 0, frame_err_o = 0; rx_busy_o low afterwards.
- 9-bit even parity, data 0x1FF with parity bit 1 → data_o = 0x1FF, no errors. Repeat with parity bit 0 → parity_err_o = 1.
- 7-bit odd parity 0x55, stop bit driven 0 → frame_err_o = 1, data_o = 0x055. Hold line low 3 bit periods → no further rx_valid_o until the line returns high and a new falling edge arrives.
- rx low for 1 cycle only (glitch shorter than half a bit) → return to IDLE, no rx_valid_o, data_o unchanged.
- Two back-to-back 6N1 frames 0x2A, 0x15 with no idle gap → two rx_valid_o pulses, data_o = 0x02A then 0x015.
- Mid-DATA: drop en, or assert rst_ni low for 1 cycle → IDLE next cycle, no pulse. After reset, all outputs are 0. A following clean frame 0x3C is received correctly.
